// File: rtl/vending_machine_change.sv
// Vending controller with a programmable price. It accepts nickels, dimes and quarters,
// pulses valid on a vend, returns any overpayment one coin per cycle using greedy coin
// selection, handles cancel/refund, and keeps a saturating count of items sold.
module vending_machine_change #(
    parameter int unsigned PRICE    = 3,
    parameter int unsigned COUNT_W  = 8,
    parameter int unsigned CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                ready,
    output logic                valid,
    output logic [1:0]          change,
    output logic [CREDIT_W-1:0] credit,
    output logic [COUNT_W-1:0]  sold
);

    typedef enum logic [1:0] {
        StCollect,
        StVend,
        StRefund
    } state_t;

    localparam logic [1:0] CoinNone    = 2'b00;
    localparam logic [1:0] CoinNickel  = 2'b01;
    localparam logic [1:0] CoinDime    = 2'b10;
    localparam logic [1:0] CoinQuarter = 2'b11;

    // Price widened to the sum width so the vend compare never truncates.
    localparam logic [CREDIT_W:0]   PriceExt = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W-1:0] CredFive = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] CredTwo  = CREDIT_W'(2);

    // Value of a coin code in nickel units, at sum width.
    function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] c);
        logic [CREDIT_W:0] v;
        case (c)
            CoinNickel:  v = (CREDIT_W + 1)'(1);
            CoinDime:    v = (CREDIT_W + 1)'(2);
            CoinQuarter: v = (CREDIT_W + 1)'(5);
            default:     v = '0;
        endcase
        return v;
    endfunction

    // Largest coin that does not exceed the remaining credit.
    function automatic logic [1:0] change_coin(input logic [CREDIT_W-1:0] c);
        logic [1:0] code;
        if (c >= CredFive) begin
            code = CoinQuarter;
        end else if (c >= CredTwo) begin
            code = CoinDime;
        end else begin
            code = CoinNickel;
        end
        return code;
    endfunction

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [COUNT_W-1:0]  sold_q;
    logic                ready_q, valid_q;
    logic [1:0]          change_q;
    logic [CREDIT_W:0]   sum;
    logic [1:0]          refund_coin;

    // Next state and next credit from the registered state, credit and sampled inputs.
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        sum         = {1'b0, credit_q} + coin_value(coin);
        refund_coin = change_coin(credit_q);
        case (state_q)
            StCollect: begin
                if (sum >= PriceExt) begin
                    // Vend wins over a cancel in the same cycle.
                    credit_d = CREDIT_W'(sum - PriceExt);
                    state_d  = StVend;
                end else if (cancel && (sum != '0)) begin
                    credit_d = CREDIT_W'(sum);
                    state_d  = StRefund;
                end else if (!cancel) begin
                    credit_d = CREDIT_W'(sum);
                end
            end
            StVend: begin
                state_d = (credit_q != '0) ? StRefund : StCollect;
            end
            StRefund: begin
                credit_d = credit_q - CREDIT_W'(coin_value(refund_coin));
                state_d  = (credit_d == '0) ? StCollect : StRefund;
            end
            default: begin
                state_d  = StCollect;
                credit_d = '0;
            end
        endcase
    end

    // State, credit and sold registers; outputs are registered from the next state so they
    // are pure functions of the state and credit held in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StCollect;
            credit_q <= '0;
            sold_q   <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            change_q <= CoinNone;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            if ((state_q == StVend) && (sold_q != '1)) begin
                sold_q <= sold_q + 1'b1;
            end
            ready_q  <= (state_d == StCollect);
            valid_q  <= (state_d == StVend);
            change_q <= (state_d == StRefund) ? change_coin(credit_d) : CoinNone;
        end
    end

    assign ready  = ready_q;
    assign valid  = valid_q;
    assign change = change_q;
    assign credit = credit_q;
    assign sold   = sold_q;

endmodule

// File: tb/tb_vending_machine_change.sv
// Bench for vending_machine_change: a PRICE=3 instance checked every cycle against a queue
// model plus literal expectations, a PRICE=1 instance for sold saturation and a PRICE=7
// instance that exercises quarter change on refund.
module tb_vending_machine_change;

    localparam int P3 = 3;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic [1:0] coin3   = 2'b00;
    logic       cancel3 = 1'b0;
    logic [1:0] coin1   = 2'b00;
    logic       cancel1 = 1'b0;
    logic [1:0] coin7   = 2'b00;
    logic       cancel7 = 1'b0;

    logic       ready3, valid3, ready1, valid1, ready7, valid7;
    logic [1:0] change3, change1, change7;
    logic [5:0] credit3, credit1, credit7;
    logic [7:0] sold3, sold1, sold7;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vending_machine_change #(.PRICE(3), .COUNT_W(8), .CREDIT_W(6)) dut3 (
        .clk(clk), .reset(reset), .coin(coin3), .cancel(cancel3), .ready(ready3),
        .valid(valid3), .change(change3), .credit(credit3), .sold(sold3)
    );

    vending_machine_change #(.PRICE(1), .COUNT_W(8), .CREDIT_W(6)) dut1 (
        .clk(clk), .reset(reset), .coin(coin1), .cancel(cancel1), .ready(ready1),
        .valid(valid1), .change(change1), .credit(credit1), .sold(sold1)
    );

    vending_machine_change #(.PRICE(7), .COUNT_W(8), .CREDIT_W(6)) dut7 (
        .clk(clk), .reset(reset), .coin(coin7), .cancel(cancel7), .ready(ready7),
        .valid(valid7), .change(change7), .credit(credit7), .sold(sold7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the PRICE=3 instance ----------------
    // Each busy phase (vend pulse, change coins) is a list of expected output cycles.
    typedef struct packed {
        logic        ready;
        logic        valid;
        logic [1:0]  change;
        logic [31:0] credit;
        logic [31:0] sold;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   m_credit;
    int   m_sold;

    function automatic int value_of(input logic [1:0] c);
        return (c == 2'd0) ? 0 : (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : 5;
    endfunction

    function automatic logic [1:0] greedy(input int r);
        return (r >= 5) ? 2'd3 : (r >= 2) ? 2'd2 : 2'd1;
    endfunction

    function automatic exp_t idle_entry();
        exp_t e;
        e.ready  = 1'b1;
        e.valid  = 1'b0;
        e.change = 2'd0;
        e.credit = m_credit;
        e.sold   = m_sold;
        return e;
    endfunction

    task automatic push_change(input int amount, input int sold_v);
        int   rem;
        exp_t e;
        rem = amount;
        while (rem > 0) begin
            e.ready  = 1'b0;
            e.valid  = 1'b0;
            e.change = greedy(rem);
            e.credit = rem;
            e.sold   = sold_v;
            q.push_back(e);
            rem -= value_of(e.change);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_credit = 0;
        m_sold   = 0;
        cur      = idle_entry();
    endtask

    task automatic model_step(input logic [1:0] c, input logic k);
        int   sum;
        int   ns;
        exp_t e;
        if (cur.ready) begin
            sum = m_credit + value_of(c);
            if (sum >= P3) begin
                ns       = (m_sold < 255) ? m_sold + 1 : 255;
                e.ready  = 1'b0;
                e.valid  = 1'b1;
                e.change = 2'd0;
                e.credit = sum - P3;
                e.sold   = m_sold;
                q.push_back(e);
                push_change(sum - P3, ns);
                m_sold   = ns;
                m_credit = 0;
            end else if (k && sum > 0) begin
                push_change(sum, m_sold);
                m_credit = 0;
            end else if (!k) begin
                m_credit = sum;
            end
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = idle_entry();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step(coin3, cancel3);
        end
    end

    // Per-cycle comparison of the PRICE=3 instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model.ready", ready3, cur.ready);
                check("model.valid", valid3, cur.valid);
                check("model.change", change3, cur.change);
                check("model.credit", credit3, cur.credit);
                check("model.sold", sold3, cur.sold);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int which, input logic [1:0] c, input logic k);
        coin3 = 2'd0; cancel3 = 1'b0;
        coin1 = 2'd0; cancel1 = 1'b0;
        coin7 = 2'd0; cancel7 = 1'b0;
        if (which == 3) begin coin3 = c; cancel3 = k; end
        if (which == 1) begin coin1 = c; cancel1 = k; end
        if (which == 7) begin coin7 = c; cancel7 = k; end
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic r, input logic v, input logic [1:0] ch,
                       input logic [5:0] cr, input logic [7:0] so, input int er, input int ev,
                       input int ech, input int ecr, input int eso);
        check({tag, ".ready"}, r, er);
        check({tag, ".valid"}, v, ev);
        check({tag, ".change"}, ch, ech);
        check({tag, ".credit"}, cr, ecr);
        check({tag, ".sold"}, so, eso);
    endtask

    task automatic lit3(input string tag, input int er, input int ev, input int ech,
                        input int ecr, input int eso);
        lit(tag, ready3, valid3, change3, credit3, sold3, er, ev, ech, ecr, eso);
    endtask

    task automatic lit7(input string tag, input int er, input int ev, input int ech,
                        input int ecr, input int eso);
        lit(tag, ready7, valid7, change7, credit7, sold7, er, ev, ech, ecr, eso);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        lit3("reset", 1, 0, 0, 0, 0);
        reset = 1'b1;

        // three nickels
        step(3, 2'd1, 1'b0); lit3("n1", 1, 0, 0, 1, 0);
        step(3, 2'd1, 1'b0); lit3("n2", 1, 0, 0, 2, 0);
        step(3, 2'd1, 1'b0); lit3("n3_vend", 0, 1, 0, 0, 0);
        step(3, 2'd0, 1'b0); lit3("n3_after", 1, 0, 0, 0, 1);

        // single quarter: vend then a dime of change
        step(3, 2'd3, 1'b0); lit3("q_vend", 0, 1, 0, 2, 1);
        step(3, 2'd0, 1'b0); lit3("q_chg", 0, 0, 2, 2, 2);
        step(3, 2'd0, 1'b0); lit3("q_done", 1, 0, 0, 0, 2);

        // dime, dime; coins held while busy are ignored
        step(3, 2'd2, 1'b0); lit3("dd1", 1, 0, 0, 2, 2);
        step(3, 2'd2, 1'b0); lit3("dd_vend", 0, 1, 0, 1, 2);
        step(3, 2'd3, 1'b0); lit3("dd_chg", 0, 0, 1, 1, 3);
        step(3, 2'd2, 1'b0); lit3("dd_done", 1, 0, 0, 0, 3);

        // cancel paths
        step(3, 2'd2, 1'b0); lit3("c_dime", 1, 0, 0, 2, 3);
        step(3, 2'd0, 1'b1); lit3("c_refund", 0, 0, 2, 2, 3);
        step(3, 2'd0, 1'b0); lit3("c_done", 1, 0, 0, 0, 3);
        step(3, 2'd0, 1'b1); lit3("c_empty", 1, 0, 0, 0, 3);
        step(3, 2'd1, 1'b1); lit3("c_nickel", 0, 0, 1, 1, 3);
        step(3, 2'd0, 1'b0); lit3("c_nickel_done", 1, 0, 0, 0, 3);
        step(3, 2'd2, 1'b0); lit3("cv_dime", 1, 0, 0, 2, 3);
        step(3, 2'd1, 1'b1); lit3("cv_vend", 0, 1, 0, 0, 3);
        step(3, 2'd0, 1'b0); lit3("cv_done", 1, 0, 0, 0, 4);

        // maximum credit PRICE+4: quarter at credit PRICE-1
        step(3, 2'd2, 1'b0); lit3("mx_dime", 1, 0, 0, 2, 4);
        step(3, 2'd3, 1'b0); lit3("mx_vend", 0, 1, 0, 4, 4);
        step(3, 2'd0, 1'b0); lit3("mx_chg1", 0, 0, 2, 4, 5);
        step(3, 2'd0, 1'b0); lit3("mx_chg2", 0, 0, 2, 2, 5);
        step(3, 2'd0, 1'b0); lit3("mx_done", 1, 0, 0, 0, 5);

        // PRICE=7: cancel at credit 6 refunds a quarter then a nickel
        step(7, 2'd3, 1'b0); lit7("p7_q", 1, 0, 0, 5, 0);
        step(7, 2'd1, 1'b0); lit7("p7_n", 1, 0, 0, 6, 0);
        step(7, 2'd0, 1'b1); lit7("p7_ref1", 0, 0, 3, 6, 0);
        step(7, 2'd0, 1'b0); lit7("p7_ref2", 0, 0, 1, 1, 0);
        step(7, 2'd0, 1'b0); lit7("p7_done", 1, 0, 0, 0, 0);
        step(7, 2'd3, 1'b0); lit7("p7_q2", 1, 0, 0, 5, 0);
        step(7, 2'd3, 1'b0); lit7("p7_vend", 0, 1, 0, 3, 0);
        step(7, 2'd0, 1'b0); lit7("p7_chg1", 0, 0, 2, 3, 1);
        step(7, 2'd0, 1'b0); lit7("p7_chg2", 0, 0, 1, 1, 1);
        step(7, 2'd0, 1'b0); lit7("p7_end", 1, 0, 0, 0, 1);

        // PRICE=1 saturation: nickel held, one vend every two cycles
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            step(1, 2'd1, 1'b0);
            check("sat.sold", sold1, ((i / 2) > 255) ? 255 : (i / 2));
            check("sat.valid", valid1, i % 2);
        end
        step(1, 2'd0, 1'b0);
        check("sat.final", sold1, 255);

        // asynchronous reset in the first refund cycle
        step(3, 2'd3, 1'b0); lit3("ar_vend", 0, 1, 0, 2, 0);
        step(3, 2'd0, 1'b0); lit3("ar_refund", 0, 0, 2, 2, 1);
        reset = 1'b0;
        #1;
        lit3("ar_async", 1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(3, 2'd0, 1'b0); lit3("ar_post", 1, 0, 0, 0, 0);
        step(3, 2'd1, 1'b0); lit3("ar_accept", 1, 0, 0, 1, 0);
        step(3, 2'd0, 1'b0);
        step(3, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_machine_change.md
Name: vending_machine_change

Overview:
Parametrised successor to the fixed-price nickel/dime vending controller. It accepts nickels, dimes and quarters and vends when accumulated credit reaches a programmable PRICE. It then returns any overpayment as change, one coin per cycle, and supports a cancel/refund request. It also keeps a saturating count of items sold, and sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

Parameters:
PRICE, 3, item price in nickel units (5 cents each); legal range 1..31
COUNT_W, 8, width of the sold-item counter
CREDIT_W, 6, credit register width; must satisfy 2^CREDIT_W > PRICE+4

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
coin  input  2  coin inserted this cycle: 00 none, 01 nickel (1 unit), 10 dime (2), 11 quarter (5)
cancel  input  1  refund request, sampled each cycle
ready  output  1  high when a coin on `coin` will be accepted this cycle
valid  output  1  one-cycle dispense pulse
change  output  2  change coin emitted this cycle, same encoding as `coin`
credit  output  CREDIT_W  current credit in nickel units
sold  output  COUNT_W  number of items vended, saturates at all-ones

Behaviour:
- reset=0 (asynchronous): state=COLLECT, credit=0, sold=0, valid=0, change=00, ready=1. All of these hold while reset stays low.
- All outputs are Moore outputs, decoded from registered state and credit only.
- Inputs are sampled on the rising edge of clk.
- States: COLLECT, VEND, REFUND.
- COLLECT: ready=1, valid=0, change=00.
  - sum = credit + value(coin), computed at CREDIT_W+1 bits.
  - If sum >= PRICE: credit <= sum-PRICE; go to VEND. Vend takes priority and a simultaneous cancel is ignored.
  - Else if cancel=1 and sum>0: credit <= sum; go to REFUND. A coin in the cancel cycle is included in the refund.
  - Else if cancel=1 and sum=0: no action; stay in COLLECT.
  - Else: credit <= sum; stay in COLLECT.
- VEND: valid=1 for exactly this one cycle; ready=0.
  - sold <= sold+1, saturating at 2^COUNT_W-1.
  - Next state: REFUND if credit>0, else COLLECT.
- REFUND: ready=0; greedy change selection each cycle:
  - credit>=5: change=11, credit -= 5
  - credit>=2: change=10, credit -= 2
  - otherwise: change=01, credit -= 1
  - Leave REFUND for COLLECT in the cycle after credit reaches 0.
  - Example: credit 2 gives one cycle of change=10, then COLLECT.
- Coins presented while ready=0 are ignored. Credit is not changed and the upstream acceptor must hold or reject them.
- cancel is ignored outside COLLECT.
- Latency: the coin completing the price is sampled at edge N. valid is high during cycle N+1. The first change coin appears in cycle N+2.
- A reset assertion mid-VEND or mid-REFUND immediately clears valid, change and credit. Any owed change is lost by design, and sold is cleared.
- Maximum credit is PRICE+4, reached when a quarter arrives at credit PRICE-1. The CREDIT_W constraint above guarantees no overflow.

Test Plan:
- PRICE=3; reset=0 for 2 cycles, then 1; coin=01 for three consecutive cycles -> valid=1 for exactly one cycle, the cycle after the third nickel is sampled; change stays 00; credit=0; sold=1; ready=1 the following cycle.
- PRICE=3; single quarter -> valid pulse, next cycle change=10, next cycle change=00 and ready=1; credit sequence 2,0; sold=1.
- PRICE=3; dime, then dime -> valid after the second dime, then one cycle change=01, then COLLECT; dime and quarter inputs held during VEND/REFUND do not alter credit.
- PRICE=3; dime, then cancel=1 with coin=00 -> no valid; change=10 for one cycle; credit 0; sold unchanged. Repeat with cancel plus nickel in the same cycle -> vend wins: valid=1, no change.
- PRICE=1; 256 nickels with COUNT_W=8 -> sold saturates at 255 and stays there.
- Reset mid-operation: PRICE=3; quarter, then drive reset=0 in the first REFUND cycle -> change=00, credit=0, sold=0 immediately (asynchronous, not waiting for clk); after release, state is COLLECT with ready=1.
